// File: rtl/intra_mb_scheduler.sv
// Frame-level sequencer for the intra-prediction path: walks macroblocks in raster order,
// pulses the neighbour extractor, then the predictor, and waits for the predictor's done.
`timescale 1ns/1ps
module intra_mb_scheduler #(
    parameter int WIDTH     = 1280,
    parameter int LENGTH    = 720,
    parameter int MB_SIZE_L = 16,
    parameter int MB_SIZE_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start_i,
    input  logic        abort_i,
    input  logic        pred_done_i,
    output logic        ext_enable_o,
    output logic [31:0] mbnumber_o,
    output logic        top_avail_o,
    output logic        left_avail_o,
    output logic        pred_start_o,
    output logic [31:0] mb_index_o,
    output logic        busy_o,
    output logic        frame_done_o
);

    localparam logic [15:0] LAST_COL = 16'(WIDTH - MB_SIZE_W);
    localparam logic [15:0] LAST_ROW = 16'(LENGTH - MB_SIZE_L);
    localparam logic [15:0] COL_STEP = 16'(MB_SIZE_W);
    localparam logic [15:0] ROW_STEP = 16'(MB_SIZE_L);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXTRACT,
        S_WAIT_EXT,
        S_PREDICT,
        S_WAIT_PRED,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] row_q, row_d;
    logic [15:0] col_q, col_d;
    logic [31:0] idx_q, idx_d;
    logic        ext_enable_d;
    logic        pred_start_d;
    logic        frame_done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            idx_q   <= idx_d;
        end
    end

    // Abort has top priority: it suppresses every pulse and any coordinate update.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        idx_d        = idx_q;
        ext_enable_d = 1'b0;
        pred_start_d = 1'b0;
        frame_done_d = 1'b0;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (frame_start_i) begin
                        row_d   = '0;
                        col_d   = '0;
                        idx_d   = '0;
                        state_d = S_EXTRACT;
                    end
                end
                S_EXTRACT: begin
                    ext_enable_d = 1'b1;
                    state_d      = S_WAIT_EXT;
                end
                S_WAIT_EXT: begin
                    state_d = S_PREDICT;
                end
                S_PREDICT: begin
                    pred_start_d = 1'b1;
                    state_d      = S_WAIT_PRED;
                end
                S_WAIT_PRED: begin
                    if (pred_done_i) begin
                        if (row_q == LAST_ROW && col_q == LAST_COL) begin
                            state_d = S_DONE;
                        end else begin
                            if (col_q == LAST_COL) begin
                                col_d = '0;
                                row_d = row_q + ROW_STEP;
                            end else begin
                                col_d = col_q + COL_STEP;
                            end
                            idx_d   = idx_q + 32'd1;
                            state_d = S_EXTRACT;
                        end
                    end
                end
                S_DONE: begin
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign ext_enable_o = ext_enable_d;
    assign pred_start_o = pred_start_d;
    assign frame_done_o = frame_done_d;
    assign mbnumber_o   = {row_q, col_q};
    assign mb_index_o   = idx_q;
    assign top_avail_o  = (row_q != '0);
    assign left_avail_o = (col_q != '0);
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_intra_mb_scheduler.sv
// Bench for intra_mb_scheduler on a 64x32 frame (8 macroblocks): table vectors, corner
// sequences (abort, async reset, spurious inputs) and random predictor latencies.
`timescale 1ns/1ps
module tb_intra_mb_scheduler;

    localparam int W          = 64;
    localparam int L          = 32;
    localparam int MB         = 16;
    localparam int MB_PER_ROW = W / MB;
    localparam int NMB        = (W / MB) * (L / MB);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start_i, abort_i, pred_done_i;
    logic        ext_enable_o, top_avail_o, left_avail_o, pred_start_o, busy_o, frame_done_o;
    logic [31:0] mbnumber_o, mb_index_o;

    always #5 clk = ~clk;

    intra_mb_scheduler #(.WIDTH(W), .LENGTH(L), .MB_SIZE_L(MB), .MB_SIZE_W(MB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start_i(frame_start_i),
        .abort_i      (abort_i),
        .pred_done_i  (pred_done_i),
        .ext_enable_o (ext_enable_o),
        .mbnumber_o   (mbnumber_o),
        .top_avail_o  (top_avail_o),
        .left_avail_o (left_avail_o),
        .pred_start_o (pred_start_o),
        .mb_index_o   (mb_index_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
    );

    typedef struct {
        logic [31:0] mbn;
        logic        top;
        logic        left;
    } vec_t;

    vec_t tbl[NMB];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ext_cnt, ps_cnt, fd_cnt;

    always @(negedge clk) begin
        if (ext_enable_o) ext_cnt++;
        if (pred_start_o) ps_cnt++;
        if (frame_done_o) fd_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic e, input logic p, input logic f,
                           input logic b);
        chk({tag, ".ext_enable"}, 32'(ext_enable_o), 32'(e));
        chk({tag, ".pred_start"}, 32'(pred_start_o), 32'(p));
        chk({tag, ".frame_done"}, 32'(frame_done_o), 32'(f));
        chk({tag, ".busy"},       32'(busy_o),       32'(b));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        frame_start_i = 1'b0;
        pred_done_i   = 1'b0;
        abort_i       = 1'b0;
    endtask

    // delay_mode: cycles from pred_start to pred_done (0 = random 1..5).
    // stop_kind: 0 none, 1 abort with pred_done on stop_mb, 2 async reset in its WAIT_PRED.
    task automatic run_frame(input int delay_mode, input bit spurious, input bit use_table,
                             input int stop_mb, input int stop_kind);
        int          t;
        int          d;
        int          row;
        int          col;
        logic [31:0] e_mbn;
        logic        e_top, e_left;
        e_mbn = '0;
        ext_cnt = 0;
        ps_cnt  = 0;
        fd_cnt  = 0;
        next_cycle();
        t = 0;
        frame_start_i = 1'b1;
        @(negedge clk);
        chk_out("start", 0, 0, 0, 0);
        for (int k = 0; k < NMB; k++) begin
            if (use_table) begin
                e_mbn  = tbl[k].mbn;
                e_top  = tbl[k].top;
                e_left = tbl[k].left;
            end else begin
                row    = (k / MB_PER_ROW) * MB;
                col    = (k % MB_PER_ROW) * MB;
                e_mbn  = {16'(row), 16'(col)};
                e_top  = (row != 0);
                e_left = (col != 0);
            end
            next_cycle(); t++;
            @(negedge clk);
            chk_out("extract", 1, 0, 0, 1);
            chk("mbnumber", mbnumber_o, e_mbn);
            chk("mb_index", mb_index_o, 32'(k));
            chk("top_avail", 32'(top_avail_o), 32'(e_top));
            chk("left_avail", 32'(left_avail_o), 32'(e_left));
            $display("MB %0d: mbnumber=0x%08h mb_index=%0d top=%0b left=%0b",
                     k, mbnumber_o, mb_index_o, top_avail_o, left_avail_o);
            next_cycle(); t++;
            if (spurious) pred_done_i = 1'b1;
            @(negedge clk);
            chk_out("wait_ext", 0, 0, 0, 1);
            next_cycle(); t++;
            @(negedge clk);
            chk_out("predict", 0, 1, 0, 1);
            d = (delay_mode > 0) ? delay_mode : int'($urandom_range(1, 5));
            for (int j = 1; j < d; j++) begin
                next_cycle(); t++;
                if (spurious && j == 1) frame_start_i = 1'b1;
                @(negedge clk);
                chk_out("wait_pred", 0, 0, 0, 1);
                chk("mbnumber_hold", mbnumber_o, e_mbn);
            end
            next_cycle(); t++;
            if (k == stop_mb && stop_kind == 2) begin
                #2 rst_n = 1'b0;
                #1;
                chk_out("async_reset", 0, 0, 0, 0);
                chk("reset_mbnumber", mbnumber_o, 32'h0);
                chk("reset_mb_index", mb_index_o, 32'h0);
                chk("reset_top", 32'(top_avail_o), 32'h0);
                chk("reset_left", 32'(left_avail_o), 32'h0);
                next_cycle();
                rst_n = 1'b1;
                next_cycle();
                pred_done_i = 1'b1;
                @(negedge clk);
                chk_out("late_pred_done", 0, 0, 0, 0);
                next_cycle();
                @(negedge clk);
                chk_out("after_reset", 0, 0, 0, 0);
                return;
            end
            pred_done_i = 1'b1;
            if (k == stop_mb && stop_kind == 1) abort_i = 1'b1;
            @(negedge clk);
            chk_out("pred_done", 0, 0, 0, 1);
            if (k == stop_mb && stop_kind == 1) begin
                next_cycle();
                @(negedge clk);
                chk_out("after_abort", 0, 0, 0, 0);
                chk("abort_mbnumber", mbnumber_o, e_mbn);
                chk("abort_mb_index", mb_index_o, 32'(k));
                next_cycle();
                @(negedge clk);
                chk_out("abort_idle", 0, 0, 0, 0);
                return;
            end
        end
        next_cycle(); t++;
        @(negedge clk);
        chk_out("done", 0, 0, 1, 1);
        chk("done_mbnumber", mbnumber_o, e_mbn);
        chk("done_mb_index", mb_index_o, 32'(NMB - 1));
        if (delay_mode == 1) chk("frame_done_cycle", 32'(t), 32'd33);
        next_cycle();
        @(negedge clk);
        chk_out("post_done", 0, 0, 0, 0);
        chk("ext_enable_count", 32'(ext_cnt), 32'(NMB));
        chk("pred_start_count", 32'(ps_cnt), 32'(NMB));
        chk("frame_done_count", 32'(fd_cnt), 32'd1);
        $display("frame complete: %0d ext_enable, %0d pred_start, %0d frame_done",
                 ext_cnt, ps_cnt, fd_cnt);
    endtask

    initial begin
        tbl[0] = '{32'h0000_0000, 1'b0, 1'b0};
        tbl[1] = '{32'h0000_0010, 1'b0, 1'b1};
        tbl[2] = '{32'h0000_0020, 1'b0, 1'b1};
        tbl[3] = '{32'h0000_0030, 1'b0, 1'b1};
        tbl[4] = '{32'h0010_0000, 1'b1, 1'b0};
        tbl[5] = '{32'h0010_0010, 1'b1, 1'b1};
        tbl[6] = '{32'h0010_0020, 1'b1, 1'b1};
        tbl[7] = '{32'h0010_0030, 1'b1, 1'b1};

        rst_n         = 1'b0;
        frame_start_i = 1'b0;
        abort_i       = 1'b0;
        pred_done_i   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 0, 0, 0, 0);
        chk("reset_mbnumber", mbnumber_o, 32'h0);
        chk("reset_mb_index", mb_index_o, 32'h0);
        rst_n = 1'b1;

        run_frame(3, 1'b0, 1'b1, -1, 0);   // full frame, 3-cycle predictor
        run_frame(1, 1'b0, 1'b0, -1, 0);   // zero-wait predictor, frame_done at cycle 33
        run_frame(3, 1'b1, 1'b1, -1, 0);   // spurious frame_start / pred_done ignored
        run_frame(3, 1'b0, 1'b1, 2, 1);    // abort together with pred_done on MB 2

        // Abort while in EXTRACT must squash the ext_enable pulse.
        next_cycle();
        frame_start_i = 1'b1;
        @(negedge clk);
        next_cycle();
        abort_i = 1'b1;
        @(negedge clk);
        chk_out("abort_extract", 0, 0, 0, 1);
        next_cycle();
        @(negedge clk);
        chk_out("abort_extract_idle", 0, 0, 0, 0);

        run_frame(3, 1'b0, 1'b1, -1, 0);   // restart after abort begins at MB 0
        run_frame(3, 1'b0, 1'b1, 5, 2);    // async reset in WAIT_PRED of MB 5
        run_frame(2, 1'b0, 1'b1, -1, 0);   // normal frame after reset

        for (int f = 0; f < 6; f++) begin
            run_frame(0, 1'($urandom_range(0, 1)), 1'b0, -1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
